// File: rtl/ppm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppm_pkg
// Brief    : Shared PPM definitions (state encoding, default frame timing)
//            used by both the encoder and the decoder so TX/RX stay matched.
// Revision : 1.0 - initial release
// ============================================================================
package ppm_pkg;

    // Frame phases of the transmitter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } ppm_state_t;

    // Default link timing
    localparam int c_PULSE_CT = 7500;
    localparam int c_N_MOD    = 2;
    localparam int c_L        = 10000;
    localparam int c_N_PKT    = 8;
    localparam int c_PRE_CT   = 4;
    localparam int c_GAP_CT   = 2;

    // Number of data symbols carried by one frame
    function automatic int ppm_data_syms(input int n_pkt, input int n_mod);
        return n_pkt / n_mod;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppm_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ppm_encoder_if
// Brief    : Host-side byte handshake (avail/read) plus the PPM pulse line
//            and busy flag of the encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface ppm_encoder_if
    import ppm_pkg::*;
#(
    parameter int N_PKT = c_N_PKT
) ();

    logic [N_PKT-1:0] data;
    logic             avail;
    logic             read;
    logic             pulse;
    logic             busy;

    // Host side: offers bytes, watches the accept strobe
    modport master (output data, avail, input read, pulse, busy);

    // Encoder side
    modport slave  (input data, avail, output read, pulse, busy);

endinterface
`default_nettype wire

// File: rtl/ppm_slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : ppm_slot_timer
// Brief    : Cycle-within-slot and slot-within-symbol counters. Reports the
//            last cycle of a symbol period and, for the following cycle,
//            the slot index and whether it lies in the pulse window.
// Revision : 1.0 - initial release
// ============================================================================
module ppm_slot_timer #(
    parameter int L        = 10000,
    parameter int N_MOD    = 2,
    parameter int PULSE_CT = 7500
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_run,
    output logic                  o_sym_end,
    output logic [N_MOD-1:0]      o_nxt_slot,
    output logic                  o_nxt_in_window
);

    localparam int c_CW = (L > 1) ? $clog2(L) : 1;

    logic [c_CW-1:0]  r_cyc;
    logic [N_MOD-1:0] r_slot;
    logic [c_CW-1:0]  w_cyc_nxt;
    logic [N_MOD-1:0] w_slot_nxt;
    logic             w_cyc_last;

    assign w_cyc_last = (r_cyc == c_CW'(L - 1));

    // Next counter values; counters sit at zero whenever the frame is not running
    always_comb begin
        w_cyc_nxt  = '0;
        w_slot_nxt = '0;
        if (i_run) begin
            if (w_cyc_last) begin
                w_cyc_nxt  = '0;
                w_slot_nxt = r_slot + 1'b1;
            end else begin
                w_cyc_nxt  = r_cyc + 1'b1;
                w_slot_nxt = r_slot;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc  <= '0;
            r_slot <= '0;
        end else begin
            r_cyc  <= w_cyc_nxt;
            r_slot <= w_slot_nxt;
        end
    end

    assign o_sym_end       = i_run && w_cyc_last && (r_slot == {N_MOD{1'b1}});
    assign o_nxt_slot      = w_slot_nxt;
    assign o_nxt_in_window = (w_cyc_nxt < c_CW'(PULSE_CT));

endmodule
`default_nettype wire

// File: rtl/ppm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ppm_encoder
// Brief    : PPM transmitter. Accepts one byte per frame over avail/read and
//            emits preamble pulses, MSB-first data symbols and an idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module ppm_encoder
    import ppm_pkg::*;
#(
    parameter int PULSE_CT = c_PULSE_CT,
    parameter int N_MOD    = c_N_MOD,
    parameter int L        = c_L,
    parameter int N_PKT    = c_N_PKT,
    parameter int PRE_CT   = c_PRE_CT,
    parameter int GAP_CT   = c_GAP_CT
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    ppm_encoder_if.slave  bus
);

    localparam int c_N_SYM = ppm_data_syms(N_PKT, N_MOD);
    localparam int c_TOTAL = PRE_CT + c_N_SYM + GAP_CT;
    localparam int c_SW    = $clog2(c_TOTAL + 1);

    // Symbol-count thresholds at which the frame moves to its next phase
    localparam logic [c_SW-1:0] c_DATA_START = c_SW'(PRE_CT);
    localparam logic [c_SW-1:0] c_GAP_START  = c_SW'(PRE_CT + c_N_SYM);
    localparam logic [c_SW-1:0] c_FRAME_END  = c_SW'(c_TOTAL);

    // Reject parameter sets that cannot produce a decodable frame
    if (PULSE_CT >= L) begin : g_chk_pulse
        $error("ppm_encoder: PULSE_CT must be smaller than L");
    end
    if ((N_PKT % N_MOD) != 0) begin : g_chk_pkt
        $error("ppm_encoder: N_PKT must be a multiple of N_MOD");
    end
    if (PRE_CT == 0) begin : g_chk_pre
        $error("ppm_encoder: PRE_CT must be nonzero");
    end

    ppm_state_t       r_state;
    logic             r_read;
    logic             r_pulse;
    logic             r_busy;
    logic [c_SW-1:0]  r_sym;
    logic [N_PKT-1:0] r_shift;

    ppm_state_t       w_state_nxt;
    logic [c_SW-1:0]  w_sym_nxt;
    logic [c_SW-1:0]  w_sym_inc;
    logic [N_PKT-1:0] w_shift_nxt;
    logic             w_pulse_nxt;
    logic             w_sym_end;
    logic [N_MOD-1:0] w_nxt_slot;
    logic             w_nxt_in_window;

    ppm_slot_timer #(
        .L        (L),
        .N_MOD    (N_MOD),
        .PULSE_CT (PULSE_CT)
    ) u_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_run           (r_state != IDLE),
        .o_sym_end       (w_sym_end),
        .o_nxt_slot      (w_nxt_slot),
        .o_nxt_in_window (w_nxt_in_window)
    );

    assign w_sym_inc = r_sym + 1'b1;

    // Next frame phase, symbol count and shift register; the pulse is
    // derived from these next values so the registered line lines up with
    // the counters it describes
    always_comb begin
        w_state_nxt = r_state;
        w_sym_nxt   = r_sym;
        w_shift_nxt = r_shift;
        w_pulse_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_read) begin
                    w_state_nxt = PRE;
                    w_sym_nxt   = '0;
                    w_shift_nxt = bus.data;
                end
            end
            PRE: begin
                if (w_sym_end) begin
                    w_sym_nxt = w_sym_inc;
                    if (w_sym_inc == c_DATA_START) begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_sym_end) begin
                    w_sym_nxt   = w_sym_inc;
                    w_shift_nxt = r_shift << N_MOD;
                    if (w_sym_inc == c_GAP_START) begin
                        w_state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (w_sym_end) begin
                    w_sym_nxt = w_sym_inc;
                    if (w_sym_inc == c_FRAME_END) begin
                        w_state_nxt = IDLE;
                        w_sym_nxt   = '0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            PRE:     w_pulse_nxt = w_nxt_in_window && (w_nxt_slot == '0);
            DATA:    w_pulse_nxt = w_nxt_in_window &&
                                   (w_nxt_slot == w_shift_nxt[N_PKT-1 -: N_MOD]);
            default: w_pulse_nxt = 1'b0;
        endcase
    end

    // Frame FSM and registered outputs; read fires in any cycle that will be
    // IDLE while avail is high, which also covers the first cycle after a gap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_sym   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sym   <= w_sym_nxt;
            r_shift <= w_shift_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_read  <= (w_state_nxt == IDLE) && bus.avail;
        end
    end

    assign bus.read  = r_read;
    assign bus.pulse = r_pulse;
    assign bus.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ppm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppm_encoder
// Brief    : Self-checking bench for ppm_encoder with short slot timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppm_encoder;
    import ppm_pkg::*;

    localparam int PULSE_CT = 3;
    localparam int N_MOD    = 2;
    localparam int L        = 4;
    localparam int N_PKT    = 8;
    localparam int PRE_CT   = 4;
    localparam int GAP_CT   = 2;
    localparam int PERIOD   = (1 << N_MOD) * L;
    localparam int N_SYM    = N_PKT / N_MOD;
    localparam int FRAME    = (PRE_CT + N_SYM + GAP_CT) * PERIOD;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ppm_encoder_if #(.N_PKT(N_PKT)) bus ();

    ppm_encoder #(
        .PULSE_CT (PULSE_CT),
        .N_MOD    (N_MOD),
        .L        (L),
        .N_PKT    (N_PKT),
        .PRE_CT   (PRE_CT),
        .GAP_CT   (GAP_CT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        int         s0, s1, s2, s3;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    bit   exp_pulse [FRAME];
    int   rises [$];
    vec_t tbl [4];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected line from the frame rules: preamble in slot 0, then one pulse
    // per symbol at the slot named by the next N_MOD bits, MSB first
    function automatic void model_frame(input logic [7:0] d);
        for (int t = 0; t < FRAME; t++) begin
            int sym  = t / PERIOD;
            int slot = (t % PERIOD) / L;
            int cyc  = t % L;
            int v;
            exp_pulse[t] = 1'b0;
            if (sym < PRE_CT) begin
                exp_pulse[t] = (slot == 0) && (cyc < PULSE_CT);
            end else if (sym < PRE_CT + N_SYM) begin
                v = (int'(d) >> (N_PKT - N_MOD * (sym - PRE_CT + 1))) & ((1 << N_MOD) - 1);
                exp_pulse[t] = (slot == v) && (cyc < PULSE_CT);
            end
        end
    endfunction

    // Expected line from hand-listed data pulse start cycles
    function automatic void table_frame(input vec_t v);
        int st [4];
        st = '{v.s0, v.s1, v.s2, v.s3};
        for (int t = 0; t < FRAME; t++) exp_pulse[t] = 1'b0;
        for (int k = 0; k < PRE_CT; k++)
            for (int c = 0; c < PULSE_CT; c++) exp_pulse[k * PERIOD + c] = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < PULSE_CT; c++) exp_pulse[st[k] + c] = 1'b1;
    endfunction

    // Wait for the accept strobe, bounded
    task automatic wait_read();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.read === 1'b1) return;
        end
        check1("read_timeout", 32'd0, 32'd1);
    endtask

    // Check cycles 0..n-1 after the read cycle; a full frame also checks the
    // first idle cycle
    task automatic frame_body(input int n, input bit exp_read_end,
                              input bit chg, input logic [7:0] nd);
        logic prev = 1'b0;
        rises.delete();
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            if (t == 0 && chg) bus.data = nd;
            check1($sformatf("pulse t=%0d", t), 32'(bus.pulse), 32'(exp_pulse[t]));
            check1($sformatf("busy t=%0d", t), 32'(bus.busy), 32'd1);
            check1($sformatf("read t=%0d", t), 32'(bus.read), 32'd0);
            if (bus.pulse === 1'b1 && prev === 1'b0) rises.push_back(t);
            prev = bus.pulse;
        end
        if (n == FRAME) begin
            @(negedge clk);
            check1("busy_end", 32'(bus.busy), 32'd0);
            check1("pulse_end", 32'(bus.pulse), 32'd0);
            check1("read_end", 32'(bus.read), 32'(exp_read_end));
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus.data  = d;
        bus.avail = 1'b1;
        wait_read();
        bus.avail = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] dec;
        tbl[0] = '{8'hB4, 72, 92, 100, 112};
        tbl[1] = '{8'hFF, 76, 92, 108, 124};
        tbl[2] = '{8'h00, 64, 80, 96, 112};
        tbl[3] = '{8'h1E, 64, 84, 108, 120};

        // Reset with avail high: nothing may come out
        rst_n     = 1'b0;
        bus.avail = 1'b1;
        bus.data  = tbl[0].data;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check1("rst_read", 32'(bus.read), 32'd0);
            check1("rst_pulse", 32'(bus.pulse), 32'd0);
            check1("rst_busy", 32'(bus.busy), 32'd0);
        end
        rst_n = 1'b1;

        // Table vectors, separate frames
        for (int i = 0; i < 3; i++) begin
            table_frame(tbl[i]);
            send(tbl[i].data);
            frame_body(FRAME, 1'b0, 1'b0, 8'h00);
        end

        // avail held across a frame: second read exactly at the first idle cycle
        model_frame(8'h5A);
        bus.data  = 8'h5A;
        bus.avail = 1'b1;
        wait_read();
        frame_body(FRAME, 1'b1, 1'b1, tbl[3].data);
        bus.avail = 1'b0;
        table_frame(tbl[3]);
        frame_body(FRAME, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a pulse (cycle 70 is high for data 8'h40)
        model_frame(8'h40);
        bus.data  = 8'h40;
        bus.avail = 1'b1;
        wait_read();
        frame_body(71, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check1("midrst_pulse", 32'(bus.pulse), 32'd0);
        check1("midrst_busy", 32'(bus.busy), 32'd0);
        check1("midrst_read", 32'(bus.read), 32'd0);
        rst_n = 1'b1;
        wait_read();
        check1("midrst_reread", 32'(bus.read), 32'd1);
        bus.avail = 1'b0;
        frame_body(FRAME, 1'b0, 1'b0, 8'h00);

        // Random bytes against the model, plus pulse-position loopback decode
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(0, 255));
            model_frame(d);
            send(d);
            frame_body(FRAME, 1'b0, 1'b0, 8'h00);
            check1("loop_npulses", 32'(rises.size()), 32'(PRE_CT + N_SYM));
            if (rises.size() == PRE_CT + N_SYM) begin
                dec = '0;
                for (int j = 0; j < N_SYM; j++)
                    dec = (dec << N_MOD) |
                          8'((rises[PRE_CT + j] - (PRE_CT + j) * PERIOD) / L);
                check1("loop_byte", 32'(dec), 32'(d));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
